// File: rtl/adc_sample_sequencer_pkg.sv
// Shared definitions for the ADC sample sequencer: code width, setpoint,
// default window thresholds, FSM state encoding and a saturating helper.
package adc_sample_sequencer_pkg;

    localparam int ADC_W = 8;

    // 1.5 V setpoint code the protection window is centred on
    localparam logic [ADC_W-1:0] VREF_CODE = 8'd192;

    // Default over/under-voltage thresholds; codes equal to a threshold are in-window
    localparam logic [ADC_W-1:0] OV_TH_DEF = 8'd208;
    localparam logic [ADC_W-1:0] UV_TH_DEF = 8'd176;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CONV = 3'd1,
        ST_WAIT = 3'd2,
        ST_CAPT = 3'd3,
        ST_HOLD = 3'd4
    } seq_state_e;

    // Increment a 4-bit debounce count, sticking at the limit once reached
    function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
        logic [3:0] res;
        if (val >= lim) begin
            res = lim;
        end else begin
            res = val + 4'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/adc_sample_sequencer_window.sv
// Window compare plus saturating debounce counter and flag for one side
// (over or under) of the voltage protection window.
module adc_window_debounce
    import adc_sample_sequencer_pkg::*;
#(
    parameter logic [ADC_W-1:0] TH    = OV_TH_DEF,
    parameter bit               IS_OV = 1'b1,
    parameter int               FLT_N = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             capt_i,
    input  logic [ADC_W-1:0] code_i,
    output logic             flag_o
);

    localparam logic [3:0] LIM = 4'(FLT_N);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       flag_q;
    logic       flag_d;
    logic       out_s;

    // Classify the captured code and compute the next debounce count and flag
    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q;
        if (IS_OV) begin
            out_s = (code_i > TH);
        end else begin
            out_s = (code_i < TH);
        end
        if (capt_i) begin
            if (out_s) begin
                cnt_d = sat_inc4(cnt_q, LIM);
            end else begin
                cnt_d = 4'd0;
            end
            flag_d = (cnt_d == LIM);
        end else begin
            cnt_d  = cnt_q;
            flag_d = flag_q;
        end
    end

    // Debounce state register, updated on the capture edge alongside the sample
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= 4'd0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/adc_sample_sequencer.sv
// ADC conversion sequencer for the buck loop: strobes convst_bar once per
// period, waits out the conversion, captures the code, pulses sample_valid
// and maintains debounced OV/UV flags around the setpoint.
module adc_sample_sequencer
    import adc_sample_sequencer_pkg::*;
#(
    parameter int               PERIOD    = 500,
    parameter int               CONV_LOW  = 4,
    parameter int               CONV_WAIT = 60,
    parameter logic [ADC_W-1:0] OV_TH     = OV_TH_DEF,
    parameter logic [ADC_W-1:0] UV_TH     = UV_TH_DEF,
    parameter int               FLT_N     = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [ADC_W-1:0] data_in_i,
    output logic             convst_bar_o,
    output logic [ADC_W-1:0] sample_o,
    output logic             sample_valid_o,
    output logic             ov_flag_o,
    output logic             uv_flag_o,
    output logic             busy_o
);

    localparam int             CNT_W    = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] CONV_END = CNT_W'(CONV_LOW - 1);
    localparam logic [CNT_W-1:0] WAIT_END = CNT_W'(CONV_LOW + CONV_WAIT - 1);

    // Parameter sanity: the capture must fit inside one period
    if (PERIOD < CONV_LOW + CONV_WAIT + 3) begin : g_bad_period
        $error("PERIOD must be at least CONV_LOW + CONV_WAIT + 3");
    end
    if ((FLT_N < 1) || (FLT_N > 15)) begin : g_bad_fltn
        $error("FLT_N must lie in 1..15");
    end
    if ((OV_TH < VREF_CODE) || (UV_TH > VREF_CODE)) begin : g_bad_window
        $error("OV/UV thresholds must bracket the setpoint code");
    end

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             capt_s;
    logic             convst_q;
    logic             busy_q;
    logic             valid_q;
    logic [ADC_W-1:0] sample_q;

    // Next-state logic; the period counter indexes clocks from the strobe fall
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capt_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CONV_END) begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_CONV;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == WAIT_END) begin
                    state_d = ST_CAPT;
                    cnt_d   = cnt_q + CNT_ONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_CAPT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    capt_s  = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HOLD: begin
                // Finish the period even if en drops so the strobe rate never glitches
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (en_i) begin
                        state_d = ST_CONV;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs; outputs derive from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            convst_q <= 1'b1;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            convst_q <= (state_d != ST_CONV);
            busy_q   <= (state_d == ST_CONV) || (state_d == ST_WAIT);
            valid_q  <= capt_s;
            if (capt_s) begin
                sample_q <= data_in_i;
            end else begin
                sample_q <= sample_q;
            end
        end
    end

    adc_window_debounce #(
        .TH    (OV_TH),
        .IS_OV (1'b1),
        .FLT_N (FLT_N)
    ) u_ov (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .capt_i (capt_s),
        .code_i (data_in_i),
        .flag_o (ov_flag_o)
    );

    adc_window_debounce #(
        .TH    (UV_TH),
        .IS_OV (1'b0),
        .FLT_N (FLT_N)
    ) u_uv (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .capt_i (capt_s),
        .code_i (data_in_i),
        .flag_o (uv_flag_o)
    );

    assign convst_bar_o   = convst_q;
    assign busy_o         = busy_q;
    assign sample_valid_o = valid_q;
    assign sample_o       = sample_q;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: period/strobe timing, capture,
// OV/UV debounce sequences, en abort and reset during conversion.
module tb_adc_sample_sequencer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [7:0] data_in_i;
    logic       convst_bar_o;
    logic [7:0] sample_o;
    logic       sample_valid_o;
    logic       ov_flag_o;
    logic       uv_flag_o;
    logic       busy_o;

    int checks_cnt = 0;
    int errors_cnt = 0;

    adc_sample_sequencer dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .data_in_i      (data_in_i),
        .convst_bar_o   (convst_bar_o),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .ov_flag_o      (ov_flag_o),
        .uv_flag_o      (uv_flag_o),
        .busy_o         (busy_o)
    );

    // 100 MHz clock
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Called in cycle F; checks one whole period and ends in the next F
    task automatic run_period(input logic [7:0] d, input logic e_ov, input logic e_uv);
        data_in_i = d;
        for (int k = 0; k < 500; k++) begin
            chk("convst", {31'd0, convst_bar_o}, (k < 4) ? 32'd0 : 32'd1);
            chk("valid", {31'd0, sample_valid_o}, (k == 65) ? 32'd1 : 32'd0);
            chk("busy", {31'd0, busy_o}, (k < 64) ? 32'd1 : 32'd0);
            if (k == 65 || k == 300) begin
                chk("sample", {24'd0, sample_o}, {24'd0, d});
                chk("ov_flag", {31'd0, ov_flag_o}, {31'd0, e_ov});
                chk("uv_flag", {31'd0, uv_flag_o}, {31'd0, e_uv});
            end
            tick();
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       ov;
        logic       uv;
    } vec_t;

    vec_t vecs[17];

    initial begin
        // setpoint, ramp 0->192, OV 210/212/215 then clear, UV 175,175,192,175,
        // threshold boundaries 209,209,208 and 176
        vecs[0]  = '{8'd192, 1'b0, 1'b0};
        vecs[1]  = '{8'd0,   1'b0, 1'b0};
        vecs[2]  = '{8'd64,  1'b0, 1'b0};
        vecs[3]  = '{8'd128, 1'b0, 1'b1};
        vecs[4]  = '{8'd192, 1'b0, 1'b0};
        vecs[5]  = '{8'd210, 1'b0, 1'b0};
        vecs[6]  = '{8'd212, 1'b0, 1'b0};
        vecs[7]  = '{8'd215, 1'b1, 1'b0};
        vecs[8]  = '{8'd192, 1'b0, 1'b0};
        vecs[9]  = '{8'd175, 1'b0, 1'b0};
        vecs[10] = '{8'd175, 1'b0, 1'b0};
        vecs[11] = '{8'd192, 1'b0, 1'b0};
        vecs[12] = '{8'd175, 1'b0, 1'b0};
        vecs[13] = '{8'd209, 1'b0, 1'b0};
        vecs[14] = '{8'd209, 1'b0, 1'b0};
        vecs[15] = '{8'd208, 1'b0, 1'b0};
        vecs[16] = '{8'd176, 1'b0, 1'b0};

        rst_i     = 1'b1;
        en_i      = 1'b0;
        data_in_i = 8'd192;
        tick();
        tick();
        chk("rst_convst", {31'd0, convst_bar_o}, 32'd1);
        chk("rst_sample", {24'd0, sample_o}, 32'd0);
        chk("rst_valid", {31'd0, sample_valid_o}, 32'd0);
        chk("rst_ov", {31'd0, ov_flag_o}, 32'd0);
        chk("rst_uv", {31'd0, uv_flag_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);

        // Idle with en low: strobe parked high
        rst_i = 1'b0;
        tick();
        tick();
        chk("idle_convst", {31'd0, convst_bar_o}, 32'd1);
        chk("idle_busy", {31'd0, busy_o}, 32'd0);

        // Enable: F is the clock after en is sampled
        en_i = 1'b1;
        tick();
        for (int v = 0; v < 17; v++) begin
            run_period(vecs[v].d, vecs[v].ov, vecs[v].uv);
        end

        // Abort during WAIT at F+20
        data_in_i = 8'd50;
        for (int k = 0; k < 20; k++) begin
            tick();
        end
        chk("wait_convst", {31'd0, convst_bar_o}, 32'd1);
        chk("wait_busy", {31'd0, busy_o}, 32'd1);
        en_i = 1'b0;
        tick();
        chk("abort_convst", {31'd0, convst_bar_o}, 32'd1);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        for (int k = 0; k < 100; k++) begin
            chk("abort_valid", {31'd0, sample_valid_o}, 32'd0);
            chk("abort_idle_convst", {31'd0, convst_bar_o}, 32'd1);
            tick();
        end
        chk("abort_sample", {24'd0, sample_o}, 32'd176);
        chk("abort_ov", {31'd0, ov_flag_o}, 32'd0);

        // Re-enable: new F one clock later, then an OV run to raise the flag
        en_i = 1'b1;
        tick();
        chk("refall_convst", {31'd0, convst_bar_o}, 32'd0);
        run_period(8'd220, 1'b0, 1'b0);
        run_period(8'd220, 1'b0, 1'b0);
        run_period(8'd220, 1'b1, 1'b0);

        // Reset in CONV (F+2) with ov_flag set and a non-zero sample held
        tick();
        tick();
        chk("conv_convst", {31'd0, convst_bar_o}, 32'd0);
        chk("pre_rst_ov", {31'd0, ov_flag_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        chk("rstc_convst", {31'd0, convst_bar_o}, 32'd1);
        chk("rstc_sample", {24'd0, sample_o}, 32'd0);
        chk("rstc_valid", {31'd0, sample_valid_o}, 32'd0);
        chk("rstc_ov", {31'd0, ov_flag_o}, 32'd0);
        chk("rstc_uv", {31'd0, uv_flag_o}, 32'd0);
        chk("rstc_busy", {31'd0, busy_o}, 32'd0);
        tick();
        chk("rsth_convst", {31'd0, convst_bar_o}, 32'd1);

        // Release: FSM was in IDLE so F follows one clock later; counters restart
        rst_i = 1'b0;
        tick();
        run_period(8'd220, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
